// File: rtl/ifetch_q_pkg.sv
// Shared definitions for the instruction fetch queue: data width and FSM
// state encodings.
package ifetch_q_pkg;

    localparam int FULLW = 32;

    // state    | meaning
    // ST_IDLE  | reset state, nothing issued
    // ST_PRIME | one cycle advancing the PC to a valid fetch address
    // ST_RUN   | issuing fetches whenever credit allows
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2
    } ifq_state_e;

    // Width of occupancy/outstanding counters: must be able to hold DEPTH itself.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/ifetch_q_slots.sv
// ifq_slots: circular slot storage for the fetch queue. Each slot holds the
// fetch address (written on allocate) and the returned instruction (written
// on fill). Slots are allocated, filled and retired strictly in order.
module ifq_slots
    import ifetch_q_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             alloc,
    input  logic [FULLW-1:0] alloc_addr,
    input  logic             fill,
    input  logic [FULLW-1:0] fill_data,
    input  logic             retire,
    output logic             head_filled,
    output logic [FULLW-1:0] head_data,
    output logic [FULLW-1:0] head_addr
);

    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0]    alloc_ptr;
    logic [PW-1:0]    fill_ptr;
    logic [PW-1:0]    ret_ptr;
    logic [DEPTH-1:0] filled;
    logic [DEPTH-1:0] filled_nxt;
    logic             bypass_hit;
    logic [FULLW-1:0] addr_mem [DEPTH];
    logic [FULLW-1:0] data_mem [DEPTH];

    // A fill and retire of the same slot can only be a bypassed response:
    // it leaves the slot without ever being stored.
    always_comb begin
        bypass_hit = fill && retire && (fill_ptr == ret_ptr);
        filled_nxt = filled;
        if (fill) begin
            filled_nxt[fill_ptr] = 1'b1;
        end
        if (retire) begin
            filled_nxt[ret_ptr] = 1'b0;
        end
    end

    // Pointers and filled flags; clear (flush) empties the queue.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alloc_ptr <= '0;
            fill_ptr  <= '0;
            ret_ptr   <= '0;
            filled    <= '0;
        end else if (clear) begin
            alloc_ptr <= '0;
            fill_ptr  <= '0;
            ret_ptr   <= '0;
            filled    <= '0;
        end else begin
            if (alloc) begin
                alloc_ptr <= alloc_ptr + PW'(1);
            end
            if (fill) begin
                fill_ptr <= fill_ptr + PW'(1);
            end
            if (retire) begin
                ret_ptr <= ret_ptr + PW'(1);
            end
            filled <= filled_nxt;
        end
    end

    // Slot payload storage; contents are only observed behind the filled flags.
    always_ff @(posedge clk) begin
        if (alloc) begin
            addr_mem[alloc_ptr] <= alloc_addr;
        end
        if (fill && !bypass_hit) begin
            data_mem[fill_ptr] <= fill_data;
        end
    end

    assign head_filled = filled[ret_ptr];
    assign head_data   = data_mem[ret_ptr];
    assign head_addr   = addr_mem[ret_ptr];

endmodule

// File: rtl/ifetch_q.sv
// ifetch_q: instruction fetch queue between the program counter, the
// instruction memory and decode. Issues fetches while credit allows, keeps
// responses in order and drops responses belonging to flushed fetches.
// Optional feature macro: IFQ_BYPASS_EN -- a response arriving to an empty
// queue is presented to decode in its arrival cycle.
module ifetch_q
    import ifetch_q_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [FULLW-1:0] iaddr,
    output logic             mod_en,
    input  logic             flush,
    output logic             mem_req,
    output logic [FULLW-1:0] mem_addr,
    input  logic             mem_rvalid,
    input  logic [FULLW-1:0] mem_rdata,
    output logic             inst_valid,
    input  logic             inst_ready,
    output logic [FULLW-1:0] inst_out,
    output logic [FULLW-1:0] inst_pc
);

    localparam int CW = cnt_width(DEPTH);
    localparam logic [CW:0] DEPTH_U = (CW+1)'(DEPTH);

    ifq_state_e    state;
    ifq_state_e    state_nxt;
    logic [CW-1:0] occ_cnt;
    logic [CW-1:0] pend_cnt;
    logic [CW-1:0] disc_cnt;
    logic [CW-1:0] occ_nxt;
    logic [CW-1:0] pend_nxt;
    logic [CW-1:0] disc_nxt;
    logic [CW:0]   usage;
    logic [CW:0]   inflight;
    logic          credit;
    logic          issue;
    logic          resp_drop;
    logic          resp_fill;
    logic          byp;
    logic          retire;
    logic          head_filled;
    logic [FULLW-1:0] head_data;
    logic [FULLW-1:0] head_addr;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: flush always restarts through PRIME.
    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = ST_PRIME;
        end else begin
            case (state)
                ST_IDLE:  state_nxt = ST_PRIME;
                ST_PRIME: state_nxt = ST_RUN;
                ST_RUN:   state_nxt = ST_RUN;
                default:  state_nxt = ST_IDLE;
            endcase
        end
    end

    // Credit and request outputs; pending discards occupy credit too.
    always_comb begin
        usage    = {1'b0, occ_cnt} + {1'b0, disc_cnt};
        credit   = usage < DEPTH_U;
        issue    = (state == ST_RUN) && credit && !flush;
        mod_en   = issue || ((state == ST_PRIME) && !flush);
        mem_req  = issue;
        mem_addr = issue ? iaddr : '0;
    end

    // Response classification: stale responses are dropped first, unsolicited ones ignored.
    always_comb begin
        resp_drop = mem_rvalid && (disc_cnt != '0);
        resp_fill = mem_rvalid && (disc_cnt == '0) && (pend_cnt != '0);
    end

    // Decode-side presentation of the head slot (or a bypassed response).
    always_comb begin
`ifdef IFQ_BYPASS_EN
        byp = resp_fill && !head_filled;
`else
        byp = 1'b0;
`endif
        inst_valid = head_filled || byp;
        inst_out   = head_filled ? head_data : (byp ? mem_rdata : '0);
        inst_pc    = inst_valid ? head_addr : '0;
        retire     = inst_valid && inst_ready;
    end

    // Counter updates; a response in the flush cycle counts as already returned.
    always_comb begin
        inflight = {1'b0, pend_cnt} + {1'b0, disc_cnt};
        if (flush) begin
            occ_nxt  = '0;
            pend_nxt = '0;
            disc_nxt = CW'(inflight - (CW+1)'(mem_rvalid && (inflight != '0)));
        end else begin
            occ_nxt  = occ_cnt + CW'(issue) - CW'(retire);
            pend_nxt = pend_cnt + CW'(issue) - CW'(resp_fill);
            disc_nxt = disc_cnt - CW'(resp_drop);
        end
    end

    // Counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            occ_cnt  <= '0;
            pend_cnt <= '0;
            disc_cnt <= '0;
        end else begin
            occ_cnt  <= occ_nxt;
            pend_cnt <= pend_nxt;
            disc_cnt <= disc_nxt;
        end
    end

    ifq_slots #(
        .DEPTH (DEPTH)
    ) u_slots (
        .clk         (clk),
        .reset       (reset),
        .clear       (flush),
        .alloc       (issue),
        .alloc_addr  (iaddr),
        .fill        (resp_fill),
        .fill_data   (mem_rdata),
        .retire      (retire),
        .head_filled (head_filled),
        .head_data   (head_data),
        .head_addr   (head_addr)
    );

endmodule

// File: tb/tb_ifetch_q.sv
// Testbench for ifetch_q: memory with configurable latency, a simple PC,
// and a reference model tracking fetch epochs and the in-order instruction list.
module tb_ifetch_q;
    import ifetch_q_pkg::*;

    localparam int DEPTH = 4;
`ifdef IFQ_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             flush = 1'b0;
    logic             mem_rvalid = 1'b0;
    logic             inst_ready = 1'b0;
    logic [FULLW-1:0] iaddr = '0;
    logic [FULLW-1:0] mem_rdata = '0;
    logic             mod_en, mem_req, inst_valid;
    logic [FULLW-1:0] mem_addr, inst_out, inst_pc;

    ifetch_q #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .iaddr      (iaddr),
        .mod_en     (mod_en),
        .flush      (flush),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .inst_out   (inst_out),
        .inst_pc    (inst_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [FULLW-1:0] addr;
        int               epoch;
        int               due;
    } mreq_t;

    typedef struct {
        logic [FULLW-1:0] addr;
        bit               ret;
    } ent_t;

    mreq_t mq[$];
    ent_t  eq[$];
    logic [FULLW-1:0] issue_log[$];
    logic [FULLW-1:0] retire_log[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int epoch = 0;
    int phase = 0;
    int last_due = 0;
    int lat_min = 1;
    int lat_max = 1;
    int n_issue = 0;
    int n_retire = 0;
    bit stale_inject = 1'b0;
    logic [FULLW-1:0] pc_next = '0;
    logic [FULLW-1:0] flush_target = 32'h0000_0100;

    bit obs_req, obs_mod, obs_valid;
    logic [FULLW-1:0] obs_addr, obs_out, obs_pc;

    function automatic logic [FULLW-1:0] mem_word(input logic [FULLW-1:0] a);
        return a ^ 32'hE3A0_0001;
    endfunction

    // One clock cycle: drive inputs, compare against the model, advance the model.
    task automatic cycle(input bit fl, input bit rdy);
        bit    resp;
        bit    exp_req, exp_mod, exp_valid;
        mreq_t r;
        ent_t  e;
        int    usage, lat, due;
        resp = 1'b0;
        r = '{default: 0};
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            resp = 1'b1;
            r = mq[0];
        end
        mem_rvalid = resp || stale_inject;
        mem_rdata  = resp ? mem_word(r.addr) : 32'hDEAD_BEEF;
        flush      = fl;
        inst_ready = rdy;
        #1;
        usage = eq.size();
        foreach (mq[i]) if (mq[i].epoch != epoch) usage++;
        exp_req = (phase == 2) && !fl && (usage < DEPTH);
        exp_mod = !fl && ((phase == 1) || exp_req);
        exp_valid = 1'b0;
        if (eq.size() > 0) exp_valid = eq[0].ret || (BYP && resp && (r.epoch == epoch));
        obs_req = mem_req; obs_mod = mod_en; obs_valid = inst_valid;
        obs_addr = mem_addr; obs_out = inst_out; obs_pc = inst_pc;
        checks++;
        if (mem_req !== exp_req) begin
            errors++;
            $display("FAIL mem_req: got %0b expected %0b (cycle %0d)", mem_req, exp_req, cyc);
        end
        checks++;
        if (mod_en !== exp_mod) begin
            errors++;
            $display("FAIL mod_en: got %0b expected %0b (cycle %0d)", mod_en, exp_mod, cyc);
        end
        if (exp_req) begin
            checks++;
            if (mem_addr !== iaddr) begin
                errors++;
                $display("FAIL mem_addr: got %h expected %h (cycle %0d)", mem_addr, iaddr, cyc);
            end
        end
        if (!fl) begin
            checks++;
            if (inst_valid !== exp_valid) begin
                errors++;
                $display("FAIL inst_valid: got %0b expected %0b (cycle %0d)", inst_valid, exp_valid, cyc);
            end
            if (exp_valid) begin
                checks++;
                if (inst_pc !== eq[0].addr || inst_out !== mem_word(eq[0].addr)) begin
                    errors++;
                    $display("FAIL inst_head: got pc %h data %h expected pc %h data %h (cycle %0d)",
                             inst_pc, inst_out, eq[0].addr, mem_word(eq[0].addr), cyc);
                end
            end
        end
        @(posedge clk);
        #1;
        if (resp) begin
            void'(mq.pop_front());
            if (r.epoch == epoch) begin
                for (int i = 0; i < eq.size(); i++) begin
                    if (!eq[i].ret) begin
                        e = eq[i];
                        e.ret = 1'b1;
                        eq[i] = e;
                        break;
                    end
                end
            end
        end
        if (!fl && exp_valid && rdy) begin
            retire_log.push_back(eq[0].addr);
            n_retire++;
            void'(eq.pop_front());
        end
        if (obs_req) begin
            lat = int'($urandom_range(lat_max, lat_min));
            due = cyc + lat;
            if (due < last_due) due = last_due;
            last_due = due;
            mq.push_back('{addr: obs_addr, epoch: epoch, due: due});
            eq.push_back('{addr: obs_addr, ret: 1'b0});
            issue_log.push_back(obs_addr);
            n_issue++;
        end
        if (fl) begin
            eq.delete();
            epoch++;
            phase = 1;
            pc_next = flush_target;
        end else if (phase < 2) begin
            phase++;
        end
        if (obs_mod) begin
            iaddr = pc_next;
            pc_next = pc_next + 32'd4;
        end
        stale_inject = 1'b0;
        cyc++;
    endtask

    // Assert reset between edges, check outputs clear at once, release mid-cycle.
    task automatic do_reset(input bit stale);
        #3;
        reset = 1'b1;
        flush = 1'b0;
        mem_rvalid = 1'b0;
        inst_ready = 1'b0;
        #1;
        checks++;
        if (mem_req !== 1'b0 || mod_en !== 1'b0 || inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got req %0b mod %0b valid %0b expected all 0", mem_req, mod_en, inst_valid);
        end
        checks++;
        if (mem_addr !== '0 || inst_out !== '0 || inst_pc !== '0) begin
            errors++;
            $display("FAIL reset_data: got addr %h out %h pc %h expected 0", mem_addr, inst_out, inst_pc);
        end
        @(posedge clk);
        #3;
        reset = 1'b0;
        mq.delete();
        eq.delete();
        issue_log.delete();
        retire_log.delete();
        epoch++;
        phase = 0;
        iaddr = '0;
        pc_next = '0;
        last_due = cyc;
        n_issue = 0;
        n_retire = 0;
        stale_inject = stale;
        cycle(1'b0, 1'b1);
    endtask

    task automatic test_reset();
        do_reset(1'b0);
        cycle(1'b0, 1'b1);
        checks++;
        if (obs_mod !== 1'b1 || obs_req !== 1'b0) begin
            errors++;
            $display("FAIL prime_cycle: got mod %0b req %0b expected mod 1 req 0", obs_mod, obs_req);
        end
    endtask

    task automatic test_in_order();
        int bad;
        lat_min = 1; lat_max = 1;
        do_reset(1'b0);
        repeat (30) cycle(1'b0, 1'b1);
        checks++;
        if (issue_log.size() < 3) begin
            errors++;
            $display("FAIL first_issues: got %0d issues expected at least 3", issue_log.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (issue_log[i] !== 32'(4 * i)) begin
                    errors++;
                    $display("FAIL issue_addr%0d: got %h expected %h", i, issue_log[i], 32'(4 * i));
                end
            end
        end
        bad = 0;
        foreach (retire_log[i]) if (retire_log[i] !== 32'(4 * i)) bad++;
        checks++;
        if (bad != 0 || retire_log.size() < 20) begin
            errors++;
            $display("FAIL retire_order: got %0d out-of-order of %0d retired expected 0 of >=20", bad, retire_log.size());
        end
    endtask

    task automatic test_credit();
        lat_min = 1; lat_max = 1;
        do_reset(1'b0);
        repeat (15) cycle(1'b0, 1'b0);
        checks++;
        if (n_issue != DEPTH) begin
            errors++;
            $display("FAIL credit_fill: got %0d issues expected %0d", n_issue, DEPTH);
        end
        cycle(1'b0, 1'b1);
        repeat (10) cycle(1'b0, 1'b0);
        checks++;
        if (n_issue != DEPTH + 1) begin
            errors++;
            $display("FAIL credit_refill: got %0d issues expected %0d", n_issue, DEPTH + 1);
        end
    endtask

    task automatic test_flush();
        int first_prime, first_issue, first_valid;
        logic [FULLW-1:0] first_pc;
        lat_min = 5; lat_max = 5;
        flush_target = 32'h0000_0100;
        do_reset(1'b0);
        for (int k = 0; k < 20 && n_issue < 3; k++) cycle(1'b0, 1'b1);
        checks++;
        if (n_issue != 3) begin
            errors++;
            $display("FAIL flush_setup: got %0d issues expected 3", n_issue);
        end
        cycle(1'b1, 1'b1);
        first_prime = -1; first_issue = -1; first_valid = -1; first_pc = '0;
        for (int k = 0; k < 30; k++) begin
            cycle(1'b0, 1'b1);
            if (obs_mod && !obs_req && first_prime < 0) first_prime = k;
            if (obs_req && first_issue < 0) first_issue = k;
            if (obs_valid && first_valid < 0) begin
                first_valid = k;
                first_pc = obs_pc;
            end
        end
        checks++;
        if (first_prime != 0 || first_issue != 1) begin
            errors++;
            $display("FAIL flush_prime: got prime %0d issue %0d expected 0 and 1", first_prime, first_issue);
        end
        checks++;
        if (first_valid != first_issue + 5 + int'(!BYP) || first_pc !== 32'h0000_0100) begin
            errors++;
            $display("FAIL flush_first_valid: got cycle %0d pc %h expected cycle %0d pc 00000100",
                     first_valid, first_pc, first_issue + 5 + int'(!BYP));
        end
    endtask

    task automatic test_back_to_back();
        int bad;
        lat_min = 1; lat_max = 1;
        do_reset(1'b0);
        repeat (100) cycle(1'b0, 1'b1);
        bad = 0;
        foreach (retire_log[i]) if (retire_log[i] !== 32'(4 * i)) bad++;
        checks++;
        if (bad != 0 || n_retire < 90) begin
            errors++;
            $display("FAIL back_to_back: got %0d retired %0d misordered expected >=90 and 0", n_retire, bad);
        end
    endtask

    task automatic test_bypass();
        int first;
        logic [FULLW-1:0] out;
        lat_min = 1; lat_max = 1;
        do_reset(1'b0);
        for (int k = 0; k < 10 && n_issue == 0; k++) cycle(1'b0, 1'b1);
        first = -1; out = '0;
        for (int k = 0; k < 4; k++) begin
            cycle(1'b0, 1'b1);
            if (obs_valid && first < 0) begin
                first = k;
                out = obs_out;
            end
        end
        checks++;
        if (first != int'(!BYP)) begin
            errors++;
            $display("FAIL bypass_latency: got %0d expected %0d", first, int'(!BYP));
        end
        checks++;
        if (out !== 32'hE3A0_0001) begin
            errors++;
            $display("FAIL bypass_data: got %h expected e3a00001", out);
        end
    endtask

    task automatic test_random();
        lat_min = 1; lat_max = 4;
        do_reset(1'b0);
        for (int k = 0; k < 400; k++) begin
            flush_target = FULLW'($urandom_range(1023)) << 2;
            cycle($urandom_range(99) < 4, $urandom_range(99) < 70);
        end
    endtask

    task automatic test_reset_mid();
        lat_min = 1; lat_max = 1;
        repeat (10) cycle(1'b0, 1'b1);
        do_reset(1'b1);
        checks++;
        if (obs_valid !== 1'b0) begin
            errors++;
            $display("FAIL stale_idle: got inst_valid %0b expected 0", obs_valid);
        end
        stale_inject = 1'b1;
        cycle(1'b0, 1'b1);
        checks++;
        if (obs_valid !== 1'b0) begin
            errors++;
            $display("FAIL stale_prime: got inst_valid %0b expected 0", obs_valid);
        end
        repeat (8) cycle(1'b0, 1'b1);
    endtask

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_in_order();
        test_credit();
        test_flush();
        test_back_to_back();
        test_bypass();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/ifetch_q.md
IFETCH_Q -- requirements
Module: ifetch_q

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning the maximum number of fetches outstanding plus queued; a power of 2, at least 2.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port iaddr, input, FULLW bits: the current fetch address from the program counter.
REQ-005 SHALL have port mod_en, output, 1 bit: advance enable to the program counter; the counter loads a new address at the edge where mod_en=1.
REQ-006 SHALL have port flush, input, 1 bit: a taken branch or program-counter write; discards all queued and in-flight fetches.
REQ-007 SHALL have port mem_req, output, 1 bit, and port mem_addr, output, FULLW bits: the instruction-memory read request and its address.
REQ-008 SHALL have port mem_rvalid, input, 1 bit, and port mem_rdata, input, FULLW bits: read responses; returned in order, latency of 1 or more cycles, unbounded.
REQ-009 SHALL have port inst_valid, output, 1 bit, port inst_ready, input, 1 bit, port inst_out, output, FULLW bits, and port inst_pc, output, FULLW bits: the decode-side valid/ready stream.

Function
REQ-010 SHALL implement FSM states IDLE, PRIME and RUN.
- IDLE is the reset state; its only exit is to PRIME on the next clock.
- PRIME lasts 1 cycle, drives mod_en=1 and mem_req=0, then moves to RUN.
REQ-011 In RUN, SHALL issue a request when credit holds: outstanding + queued < DEPTH.
- On issue: mem_req=1, mem_addr=iaddr and mod_en=1 in the same cycle.
- Without credit: mem_req=0 and mod_en=0, so the program counter holds.
REQ-012 mem_req, mem_addr and mod_en SHALL be combinational from state, credit and flush.
REQ-013 Each issue SHALL allocate a slot holding the issuing iaddr.
REQ-014 Each accepted response SHALL fill the oldest unfilled slot with mem_rdata.
REQ-015 Slots SHALL be presented oldest-first; inst_valid=1 only while the head slot is filled.
- inst_out is the head data; inst_pc is the head address.
REQ-016 The head slot SHALL retire on a cycle where inst_valid and inst_ready are both 1.
- The head stays stable while inst_valid=1 and inst_ready=0.
REQ-017 Issue, response and retire in the same cycle SHALL all take effect; credit is computed from pre-edge counts.
REQ-018 flush=1 SHALL have priority over all other events.
- Force mem_req=0 and mod_en=0 that cycle; clear all slots; inst_valid=0 from the next cycle.
- Load discard counter = outstanding requests not yet returned, counting a response arriving in the flush cycle as returned.
- Enter PRIME.
REQ-019 While the discard counter is non-zero, responses SHALL be dropped and the counter decremented; it gates credit like outstanding requests.
REQ-020 A flush during PRIME or IDLE SHALL re-enter PRIME; no request is issued.
REQ-021 Counters SHALL be log2(DEPTH)+1 bits wide and SHALL never overflow, since credit bounds them.
- Slot pointers wrap modulo DEPTH.
REQ-022 A mem_rvalid with no outstanding request SHALL be ignored.

Reset
REQ-023 Asserting reset SHALL immediately force the following, independent of clk:
- state=IDLE;
- all counters and pointers cleared;
- mem_req=0, mod_en=0, inst_valid=0;
- mem_addr, inst_out and inst_pc = 0.
REQ-024 Reset asserted mid-operation SHALL drop all fetches; responses arriving after release are ignored per REQ-022.

Configuration
REQ-025 With IFQ_BYPASS_EN defined, a response arriving while no filled slot is queued SHALL drive inst_valid/inst_out/inst_pc combinationally in the same cycle.
- It retires without being written if inst_ready=1.
REQ-026 Without IFQ_BYPASS_EN, every response SHALL be written to its slot first, giving a minimum 1-cycle response-to-inst_valid latency.

Structure
REQ-027 FULLW and the FSM state encodings SHALL live in the shared defines header.
REQ-028 Slot storage SHALL be one sub-module, ifq_slots, with allocate, fill and retire pointers and the per-slot filled flags; ifetch_q holds the FSM, counters and credit logic.

Verification
REQ-029 Reset release, memory latency 1, inst_ready=1: PRIME cycle, then mem_addr 0, 4, 8…; instructions appear in order with inst_pc matching.
REQ-030 DEPTH=4, inst_ready=0, latency 1: exactly 4 issues, then mod_en=0 and mem_req=0; one retire re-enables exactly one issue.
REQ-031 Latency 5, flush with 3 outstanding: next 3 responses dropped; no inst_valid until the first post-flush fetch returns; PRIME occurs before it.
REQ-032 Issue, response and retire in the same cycle at full credit: counts unchanged and no lost or duplicated instruction over 100 cycles.
REQ-033 With IFQ_BYPASS_EN, an empty queue and inst_ready=1: the response 0xE3A00001 appears on inst_out in its arrival cycle; without the macro, it appears one cycle later.
REQ-034 Reset pulse asserted mid-stream between clock edges: outputs clear immediately; a stale mem_rvalid after release produces no inst_valid.
